// File: rtl/vga_timing_gen.sv
// VGA pixel timing: divides the board clock into a pixel enable, runs h/v counters, and emits
// registered coordinates, delayed sync/video flags, line/frame strobes and a frame counter.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_PULSE   = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_PULSE   = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int PIPE_DLY  = 1
) (
  input  logic       i_clk_50mhz,
  input  logic       i_reset,
  input  logic       i_enable,
  output logic       o_pix_tick,
  output logic [9:0] o_pixel_x,
  output logic [9:0] o_pixel_y,
  output logic       o_video_on,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_line_start,
  output logic       o_frame_start,
  output logic [7:0] o_frame_count
);

  localparam logic [9:0] H_LAST = 10'(H_DISPLAY + H_FRONT + H_PULSE + H_BACK - 1);
  localparam logic [9:0] V_LAST = 10'(V_DISPLAY + V_FRONT + V_PULSE + V_BACK - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
  localparam logic [9:0] H_SS   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] H_SE   = 10'(H_DISPLAY + H_FRONT + H_PULSE);
  localparam logic [9:0] V_SS   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] V_SE   = 10'(V_DISPLAY + V_FRONT + V_PULSE);

  if (PIPE_DLY < 1 || PIPE_DLY > 7) begin : g_bad_pipe_dly
    $error("vga_timing_gen: PIPE_DLY must be in 1..7");
  end

  logic                r_tick;
  logic [9:0]          r_x;
  logic [9:0]          r_y;
  logic [7:0]          r_fcnt;
  logic                r_line;
  logic                r_frame;
  logic [PIPE_DLY-1:0] r_vid_d;
  logic [PIPE_DLY-1:0] r_hs_d;
  logic [PIPE_DLY-1:0] r_vs_d;

  logic       w_upd;
  logic       w_x_wrap;
  logic       w_y_wrap;
  logic [9:0] w_x_nxt;
  logic [9:0] w_y_nxt;
  logic       w_vid;
  logic       w_hs;
  logic       w_vs;

  assign w_upd    = r_tick & i_enable;
  assign w_x_wrap = (r_x == H_LAST);
  assign w_y_wrap = (r_y == V_LAST);
  assign w_x_nxt  = w_x_wrap ? 10'd0 : r_x + 10'd1;
  assign w_y_nxt  = w_x_wrap ? (w_y_wrap ? 10'd0 : r_y + 10'd1) : r_y;

  // Raw decode of the current count; the delay line realigns it with the renderer output.
  assign w_vid = (r_x < H_VIS) && (r_y < V_VIS);
  assign w_hs  = ((r_x >= H_SS) && (r_x < H_SE)) ? SYNC_POL : ~SYNC_POL;
  assign w_vs  = ((r_y >= V_SS) && (r_y < V_SE)) ? SYNC_POL : ~SYNC_POL;

  always_ff @(posedge i_clk_50mhz or posedge i_reset) begin
    if (i_reset) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= ~r_tick;
    end
  end

  always_ff @(posedge i_clk_50mhz or posedge i_reset) begin
    if (i_reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_fcnt  <= '0;
      r_line  <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      r_line  <= w_upd & w_x_wrap;
      r_frame <= w_upd & w_x_wrap & w_y_wrap;
      if (w_upd) begin
        r_x <= w_x_nxt;
        r_y <= w_y_nxt;
        if (w_x_wrap && w_y_wrap) begin
          r_fcnt <= r_fcnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk_50mhz or posedge i_reset) begin
    if (i_reset) begin
      r_vid_d <= '0;
      r_hs_d  <= {PIPE_DLY{~SYNC_POL}};
      r_vs_d  <= {PIPE_DLY{~SYNC_POL}};
    end else if (w_upd) begin
      r_vid_d[0] <= w_vid;
      r_hs_d[0]  <= w_hs;
      r_vs_d[0]  <= w_vs;
      for (int i = 1; i < PIPE_DLY; i++) begin
        r_vid_d[i] <= r_vid_d[i-1];
        r_hs_d[i]  <= r_hs_d[i-1];
        r_vs_d[i]  <= r_vs_d[i-1];
      end
    end
  end

  assign o_pix_tick    = r_tick;
  assign o_pixel_x     = r_x;
  assign o_pixel_y     = r_y;
  assign o_video_on    = r_vid_d[PIPE_DLY-1];
  assign o_hsync       = r_hs_d[PIPE_DLY-1];
  assign o_vsync       = r_vs_d[PIPE_DLY-1];
  assign o_line_start  = r_line;
  assign o_frame_start = r_frame;
  assign o_frame_count = r_fcnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size 640x480 instance plus a tiny-geometry instance (PIPE_DLY=3)
// so frame-level behaviour and frame_count wrap fit in a short run; both follow a tick-count model.
module tb_vga_timing_gen;

  localparam int SHD = 4, SHF = 1, SHP = 2, SHB = 1;
  localparam int SVD = 3, SVF = 1, SVP = 1, SVB = 1;
  localparam int SDLY = 3;
  localparam int SHT = SHD + SHF + SHP + SHB;
  localparam int SFT = SHT * (SVD + SVF + SVP + SVB);
  localparam int FHT = 800;
  localparam int FFT = 800 * 525;

  typedef logic [33:0] ovec_t;
  localparam ovec_t RST_VEC = {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  always #10 clk = ~clk;

  logic       f_tick, f_vid, f_hs, f_vs, f_ls, f_fs;
  logic [9:0] f_x, f_y;
  logic [7:0] f_fc;
  logic       s_tick, s_vid, s_hs, s_vs, s_ls, s_fs;
  logic [9:0] s_x, s_y;
  logic [7:0] s_fc;

  vga_timing_gen u_full (
    .i_clk_50mhz(clk), .i_reset(rst), .i_enable(en),
    .o_pix_tick(f_tick), .o_pixel_x(f_x), .o_pixel_y(f_y), .o_video_on(f_vid),
    .o_hsync(f_hs), .o_vsync(f_vs), .o_line_start(f_ls), .o_frame_start(f_fs),
    .o_frame_count(f_fc)
  );

  vga_timing_gen #(
    .H_DISPLAY(SHD), .H_FRONT(SHF), .H_PULSE(SHP), .H_BACK(SHB),
    .V_DISPLAY(SVD), .V_FRONT(SVF), .V_PULSE(SVP), .V_BACK(SVB),
    .SYNC_POL(1'b0), .PIPE_DLY(SDLY)
  ) u_small (
    .i_clk_50mhz(clk), .i_reset(rst), .i_enable(en),
    .o_pix_tick(s_tick), .o_pixel_x(s_x), .o_pixel_y(s_y), .o_video_on(s_vid),
    .o_hsync(s_hs), .o_vsync(s_vs), .o_line_start(s_ls), .o_frame_start(s_fs),
    .o_frame_count(s_fc)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model state: tick phase and number of pixel advances since reset.
  logic m_tick;
  int   m_n;
  logic m_ls_f, m_fs_f, m_ls_s, m_fs_s;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tick <= 1'b0;
      m_n    <= 0;
      m_ls_f <= 1'b0; m_fs_f <= 1'b0; m_ls_s <= 1'b0; m_fs_s <= 1'b0;
    end else begin
      m_tick <= ~m_tick;
      if (m_tick && en) begin
        m_n    <= m_n + 1;
        m_ls_f <= ((m_n + 1) % FHT) == 0;
        m_fs_f <= ((m_n + 1) % FFT) == 0;
        m_ls_s <= ((m_n + 1) % SHT) == 0;
        m_fs_s <= ((m_n + 1) % SFT) == 0;
      end else begin
        m_ls_f <= 1'b0; m_fs_f <= 1'b0; m_ls_s <= 1'b0; m_fs_s <= 1'b0;
      end
    end
  end

  // Expected outputs after n pixel advances: sync/video describe the pixel d advances earlier.
  function automatic ovec_t model_vec(input int n, input logic tick, input logic ls, input logic fs,
                                      input int hd, input int hf, input int hp, input int hb,
                                      input int vd, input int vf, input int vp, input int vb,
                                      input int d);
    int ht, vt, k, h, v;
    logic vid, hs, vs;
    ht = hd + hf + hp + hb;
    vt = vd + vf + vp + vb;
    k  = n - d;
    vid = 1'b0; hs = 1'b1; vs = 1'b1;
    if (k >= 0) begin
      h   = k % ht;
      v   = (k / ht) % vt;
      vid = (h < hd) && (v < vd);
      hs  = !((h >= hd + hf) && (h < hd + hf + hp));
      vs  = !((v >= vd + vf) && (v < vd + vf + vp));
    end
    return {tick, 10'(n % ht), 10'((n / ht) % vt), vid, hs, vs, ls, fs, 8'((n / (ht * vt)) % 256)};
  endfunction

  ovec_t f_obs, s_obs, f_exp, s_exp;
  assign f_obs = {f_tick, f_x, f_y, f_vid, f_hs, f_vs, f_ls, f_fs, f_fc};
  assign s_obs = {s_tick, s_x, s_y, s_vid, s_hs, s_vs, s_ls, s_fs, s_fc};
  assign f_exp = model_vec(m_n, m_tick, m_ls_f, m_fs_f, 640, 16, 96, 48, 480, 10, 2, 33, 1);
  assign s_exp = model_vec(m_n, m_tick, m_ls_s, m_fs_s, SHD, SHF, SHP, SHB, SVD, SVF, SVP, SVB, SDLY);

  task automatic test_reset();
    rst = 1'b0; en = 1'b0;
    #1 rst = 1'b1;
    #4;
    vectors++;
    if (f_obs !== RST_VEC) begin miscompares++; $display("FAIL reset_full got %h want %h", f_obs, RST_VEC); end
    vectors++;
    if (s_obs !== RST_VEC) begin miscompares++; $display("FAIL reset_small got %h want %h", s_obs, RST_VEC); end
    en = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (f_obs !== RST_VEC) begin miscompares++; $display("FAIL reset_held got %h want %h", f_obs, RST_VEC); end
    rst = 1'b0;
  endtask

  task automatic test_counting();
    int nls, xmax;
    nls = 0; xmax = 0;
    for (int c = 0; c < 3400; c++) begin
      @(negedge clk);
      vectors++;
      if (f_obs !== f_exp) begin miscompares++; $display("FAIL count_full c=%0d got %h want %h", c, f_obs, f_exp); end
      vectors++;
      if (s_obs !== s_exp) begin miscompares++; $display("FAIL count_small c=%0d got %h want %h", c, s_obs, s_exp); end
      if (f_ls === 1'b1) nls++;
      if (int'(f_x) > xmax) xmax = int'(f_x);
    end
    vectors++;
    if (nls !== 2) begin miscompares++; $display("FAIL line_start_pulses got %0d want 2", nls); end
    vectors++;
    if (xmax !== 799) begin miscompares++; $display("FAIL pixel_x_max got %0d want 799", xmax); end
  endtask

  task automatic test_enable_hold();
    int guard;
    guard = 0;
    while ((m_n % FHT) != 320 && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (guard >= 4000) begin miscompares++; $display("FAIL hold_reach_320 timeout got x=%0d want 320", f_x); end
    en = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      vectors++;
      if (f_obs !== f_exp || f_x !== 10'd320) begin
        miscompares++; $display("FAIL hold_full c=%0d got %h want %h", c, f_obs, f_exp);
      end
      vectors++;
      if (s_obs !== s_exp) begin miscompares++; $display("FAIL hold_small c=%0d got %h want %h", c, s_obs, s_exp); end
    end
    en = 1'b1;
    guard = 0;
    while (f_x === 10'd320 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (f_x !== 10'd321) begin miscompares++; $display("FAIL resume_next got %0d want 321", f_x); end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      en = ($urandom_range(0, 3) != 0);
      vectors++;
      if (f_obs !== f_exp) begin miscompares++; $display("FAIL rand_en_full c=%0d got %h want %h", c, f_obs, f_exp); end
      vectors++;
      if (s_obs !== s_exp) begin miscompares++; $display("FAIL rand_en_small c=%0d got %h want %h", c, s_obs, s_exp); end
    end
    @(negedge clk);
    en = 1'b1;
  endtask

  task automatic test_frames();
    int last_fs, nwrap;
    logic [7:0] prev_fc;
    last_fs = -1; nwrap = 0; prev_fc = s_fc;
    for (int c = 0; c < 260 * 2 * SFT; c++) begin
      @(negedge clk);
      vectors++;
      if (s_obs !== s_exp) begin miscompares++; $display("FAIL frame_small c=%0d got %h want %h", c, s_obs, s_exp); end
      vectors++;
      if (f_obs !== f_exp) begin miscompares++; $display("FAIL frame_full c=%0d got %h want %h", c, f_obs, f_exp); end
      if (s_fs === 1'b1) begin
        vectors++;
        if (s_fc !== 8'(prev_fc + 8'd1)) begin
          miscompares++; $display("FAIL frame_count_step got %0d want %0d", s_fc, 8'(prev_fc + 8'd1));
        end
        if (prev_fc == 8'd255) nwrap++;
        if (last_fs >= 0) begin
          vectors++;
          if (c - last_fs !== 2 * SFT) begin
            miscompares++; $display("FAIL frame_period got %0d want %0d", c - last_fs, 2 * SFT);
          end
        end
        last_fs = c;
      end
      prev_fc = s_fc;
    end
    vectors++;
    if (nwrap !== 1) begin miscompares++; $display("FAIL frame_count_wraps got %0d want 1", nwrap); end
  endtask

  task automatic test_reset_midframe();
    int guard, nfs;
    guard = 0; nfs = 0;
    while ((m_n % FHT) != 500 && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (guard >= 4000) begin miscompares++; $display("FAIL midreset_reach timeout got x=%0d want 500", f_x); end
    @(posedge clk);
    #2 rst = 1'b1;
    #2;
    vectors++;
    if (f_obs !== RST_VEC) begin miscompares++; $display("FAIL midreset_full got %h want %h", f_obs, RST_VEC); end
    vectors++;
    if (s_obs !== RST_VEC) begin miscompares++; $display("FAIL midreset_small got %h want %h", s_obs, RST_VEC); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 90; c++) begin
      @(negedge clk);
      vectors++;
      if (f_obs !== f_exp) begin miscompares++; $display("FAIL restart_full c=%0d got %h want %h", c, f_obs, f_exp); end
      vectors++;
      if (s_obs !== s_exp) begin miscompares++; $display("FAIL restart_small c=%0d got %h want %h", c, s_obs, s_exp); end
      if (f_fs === 1'b1 || s_fs === 1'b1) nfs++;
    end
    vectors++;
    if (nfs !== 0) begin miscompares++; $display("FAIL restart_frame_start got %0d want 0", nfs); end
  endtask

  initial begin
    test_reset();
    test_counting();
    test_enable_hold();
    test_frames();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
